// File: rtl/stack_seq.sv
// Stack sequencer for the 2A03 core: owns SP and runs the multi-cycle
// push (JSR/BRK/IRQ/NMI) and pull (RTS/RTI) byte sequences on page 1.
module stack_seq #(
    parameter logic [7:0] STACK_PAGE = 8'h01,
    parameter logic [7:0] SP_RESET   = 8'hFD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_push,
    input  logic        start_pull,
    input  logic        with_p,
    input  logic [7:0]  pc_h_in,
    input  logic [7:0]  pc_l_in,
    input  logic [7:0]  p_in,
    input  logic        sp_load,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [7:0]  sp_out,
    output logic [7:0]  pc_h_out,
    output logic [7:0]  pc_l_out,
    output logic [7:0]  p_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, PUSH, PULL, PULL_TAIL, DONE} state_t;

    // Destination codes for pulled bytes; a read's code is its index shifted
    // by one when P is absent, so PC_L/PC_H always keep the same codes.
    localparam logic [1:0] DEST_P    = 2'd0;
    localparam logic [1:0] DEST_PC_L = 2'd1;

    state_t     state;
    logic [7:0] sp;
    logic [1:0] idx;
    logic [1:0] last;
    logic [1:0] cap_dest;
    logic       wp;
    logic [7:0] push_l;
    logic [7:0] push_p;

    logic [7:0] sp_inc;
    logic [7:0] sp_inc2;
    logic [7:0] sp_dec;
    logic [7:0] next_push_byte;
    logic [1:0] rd_dest;

    assign sp_inc  = sp + 8'd1;
    assign sp_inc2 = sp + 8'd2;
    assign sp_dec  = sp - 8'd1;
    assign sp_out  = sp;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_push_byte = push_p;
        if (idx == 2'd0)
            next_push_byte = push_l;
    end

    assign rd_dest = wp ? idx : idx + 2'd1;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sp        <= SP_RESET;
            idx       <= 2'd0;
            last      <= 2'd0;
            cap_dest  <= 2'd0;
            wp        <= 1'b0;
            push_l    <= 8'h00;
            push_p    <= 8'h00;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            pc_h_out  <= 8'h00;
            pc_l_out  <= 8'h00;
            p_out     <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= 2'd0;
                    if (start_push) begin
                        push_l    <= pc_l_in;
                        push_p    <= p_in;
                        wp        <= with_p;
                        last      <= with_p ? 2'd2 : 2'd1;
                        state     <= PUSH;
                        busy      <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {STACK_PAGE, sp};
                        mem_wdata <= pc_h_in;
                    end else if (start_pull) begin
                        wp       <= with_p;
                        last     <= with_p ? 2'd2 : 2'd1;
                        state    <= PULL;
                        busy     <= 1'b1;
                        mem_re   <= 1'b1;
                        mem_addr <= {STACK_PAGE, sp_inc};
                    end else if (sp_load) begin
                        sp <= sp_in;
                    end
                end

                PUSH: begin
                    sp <= sp_dec;
                    if (idx == last) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= 16'h0000;
                        mem_wdata <= 8'h00;
                    end else begin
                        idx       <= idx + 2'd1;
                        mem_addr  <= {STACK_PAGE, sp_dec};
                        mem_wdata <= next_push_byte;
                    end
                end

                PULL: begin
                    sp       <= sp_inc;
                    cap_dest <= rd_dest;
                    // Data for the previous cycle's read is on mem_rdata now.
                    if (idx != 2'd0) begin
                        case (cap_dest)
                            DEST_P:    p_out    <= mem_rdata;
                            DEST_PC_L: pc_l_out <= mem_rdata;
                            default:   pc_h_out <= mem_rdata;
                        endcase
                    end
                    if (idx == last) begin
                        state    <= PULL_TAIL;
                        mem_re   <= 1'b0;
                        mem_addr <= 16'h0000;
                    end else begin
                        idx      <= idx + 2'd1;
                        mem_addr <= {STACK_PAGE, sp_inc2};
                    end
                end

                PULL_TAIL: begin
                    case (cap_dest)
                        DEST_P:    p_out    <= mem_rdata;
                        DEST_PC_L: pc_l_out <= mem_rdata;
                        default:   pc_h_out <= mem_rdata;
                    endcase
                    state <= DONE;
                    done  <= 1'b1;
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    mem_we   <= 1'b0;
                    mem_re   <= 1'b0;
                    mem_addr <= 16'h0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: directed test-plan steps followed by
// random push/pull/TXS traffic, checked against a page-1 stack model.
module tb_stack_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_push, start_pull, with_p;
    logic [7:0]  pc_h_in, pc_l_in, p_in;
    logic        sp_load;
    logic [7:0]  sp_in;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, mem_re;
    logic [7:0]  sp_out, pc_h_out, pc_l_out, p_out;
    logic        busy, done;

    int n_cmp = 0;
    int n_err = 0;

    // Bus-side memory serving the DUT, and the model's own view of the stack.
    logic [7:0] bus_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ref_sp, ref_pch, ref_pcl, ref_p;

    stack_seq dut (
        .clk(clk), .reset(reset),
        .start_push(start_push), .start_pull(start_pull), .with_p(with_p),
        .pc_h_in(pc_h_in), .pc_l_in(pc_l_in), .p_in(p_in),
        .sp_load(sp_load), .sp_in(sp_in), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .sp_out(sp_out), .pc_h_out(pc_h_out), .pc_l_out(pc_l_out), .p_out(p_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= mem_re ? bus_mem[mem_addr[7:0]] : 8'h00;
        if (mem_we)
            bus_mem[mem_addr[7:0]] = mem_wdata;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_checks();
        check("idle_busy", {15'd0, busy}, 16'd0);
        check("idle_done", {15'd0, done}, 16'd0);
        check("idle_we", {15'd0, mem_we}, 16'd0);
        check("idle_re", {15'd0, mem_re}, 16'd0);
        check("idle_addr", mem_addr, 16'h0000);
        check("idle_sp", {8'd0, sp_out}, {8'd0, ref_sp});
    endtask

    task automatic drive(input logic psh, input logic pul, input logic wp, input logic ld);
        start_push = psh;
        start_pull = pul;
        with_p     = wp;
        sp_load    = ld;
        sp_in      = 8'($urandom);
    endtask

    // One full push; noise holds starts and sp_load high while busy.
    task automatic do_push(input logic wp, input logic [7:0] h, input logic [7:0] l,
                           input logic [7:0] p, input logic both, input logic noise);
        logic [7:0] bytes [3];
        int n;
        bytes[0] = h; bytes[1] = l; bytes[2] = p;
        n = wp ? 3 : 2;
        @(negedge clk);
        idle_checks();
        drive(1'b1, both, wp, noise);
        pc_h_in = h; pc_l_in = l; p_in = p;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("push_we", {15'd0, mem_we}, 16'd1);
            check("push_re", {15'd0, mem_re}, 16'd0);
            check("push_addr", mem_addr, {8'h01, ref_sp});
            check("push_wdata", {8'd0, mem_wdata}, {8'd0, bytes[i]});
            check("push_busy", {15'd0, busy}, 16'd1);
            check("push_done", {15'd0, done}, 16'd0);
            ref_mem[ref_sp] = bytes[i];
            ref_sp = ref_sp - 8'd1;
            drive(noise, noise, $urandom_range(0, 1) == 1, noise);
            pc_h_in = 8'($urandom); pc_l_in = 8'($urandom); p_in = 8'($urandom);
        end
        @(negedge clk);
        check("push_done_pulse", {15'd0, done}, 16'd1);
        check("push_done_busy", {15'd0, busy}, 16'd1);
        check("push_done_we", {15'd0, mem_we}, 16'd0);
        check("push_done_sp", {8'd0, sp_out}, {8'd0, ref_sp});
        drive(noise, noise, wp, noise);
    endtask

    // One full pull; with_p order is P, PC_L, PC_H, otherwise PC_L, PC_H.
    task automatic do_pull(input logic wp, input logic noise);
        int n;
        logic [7:0] a;
        logic [7:0] got [3];
        n = wp ? 3 : 2;
        @(negedge clk);
        idle_checks();
        drive(1'b0, 1'b1, wp, noise);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a = ref_sp + 8'd1;
            check("pull_re", {15'd0, mem_re}, 16'd1);
            check("pull_we", {15'd0, mem_we}, 16'd0);
            check("pull_addr", mem_addr, {8'h01, a});
            check("pull_busy", {15'd0, busy}, 16'd1);
            got[i] = ref_mem[a];
            ref_sp = a;
            drive(noise, noise, $urandom_range(0, 1) == 1, noise);
        end
        if (wp) begin
            ref_p = got[0]; ref_pcl = got[1]; ref_pch = got[2];
        end else begin
            ref_pcl = got[0]; ref_pch = got[1];
        end
        @(negedge clk);
        check("tail_re", {15'd0, mem_re}, 16'd0);
        check("tail_addr", mem_addr, 16'h0000);
        check("tail_busy", {15'd0, busy}, 16'd1);
        check("tail_done", {15'd0, done}, 16'd0);
        @(negedge clk);
        check("pull_done_pulse", {15'd0, done}, 16'd1);
        check("pull_pch", {8'd0, pc_h_out}, {8'd0, ref_pch});
        check("pull_pcl", {8'd0, pc_l_out}, {8'd0, ref_pcl});
        check("pull_p", {8'd0, p_out}, {8'd0, ref_p});
        check("pull_sp", {8'd0, sp_out}, {8'd0, ref_sp});
        drive(noise, noise, wp, noise);
    endtask

    task automatic load_sp(input logic [7:0] v);
        @(negedge clk);
        idle_checks();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        sp_in  = v;
        ref_sp = v;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            bus_mem[i] = ref_mem[i];
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        pc_h_in = 8'h00; pc_l_in = 8'h00; p_in = 8'h00;
        ref_sp = 8'hFD; ref_pch = 8'h00; ref_pcl = 8'h00; ref_p = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_sp", {8'd0, sp_out}, 16'h00FD);
        check("rst_wdata", {8'd0, mem_wdata}, 16'h0000);
        check("rst_pch", {8'd0, pc_h_out}, 16'h0000);
        check("rst_p", {8'd0, p_out}, 16'h0000);
        idle_checks();
        reset = 1'b0;

        // Directed: 3-byte push then pull back from FD.
        do_push(1'b1, 8'hC0, 8'h12, 8'h24, 1'b0, 1'b0);
        do_pull(1'b1, 1'b0);

        // Wrap around the bottom of the page with 2-byte sequences.
        load_sp(8'h01);
        do_push(1'b0, 8'hAB, 8'hCD, 8'hEE, 1'b0, 1'b0);
        do_pull(1'b0, 1'b0);

        // Push wins over a simultaneous pull; busy-time starts/sp_load ignored.
        do_push(1'b1, 8'h5A, 8'hA5, 8'h3C, 1'b1, 1'b1);

        // Reset during the second push cycle.
        @(negedge clk);
        idle_checks();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        pc_h_in = 8'h11; pc_l_in = 8'h22; p_in = 8'h33;
        @(negedge clk);
        check("rp1_addr", mem_addr, {8'h01, ref_sp});
        ref_mem[ref_sp] = 8'h11;
        ref_sp = ref_sp - 8'd1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rp2_we", {15'd0, mem_we}, 16'd1);
        ref_mem[ref_sp] = 8'h22;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ref_sp = 8'hFD; ref_pch = 8'h00; ref_pcl = 8'h00; ref_p = 8'h00;
        check("rstmid_pch", {8'd0, pc_h_out}, 16'h0000);
        check("rstmid_wdata", {8'd0, mem_wdata}, 16'h0000);
        idle_checks();

        // Back-to-back: start_pull in DONE is dropped, next IDLE start accepted.
        do_pull(1'b1, 1'b1);
        do_pull(1'b0, 1'b0);

        // Random traffic.
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 2))
                0: do_push($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom),
                           8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                1: do_pull($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                default: load_sp(8'($urandom));
            endcase
        end

        @(negedge clk);
        idle_checks();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        idle_checks();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Multi-cycle stack sequencer for the 2A03 core.
- Owns the 8-bit stack pointer (SP).
- Push: writes a captured program counter (high/low bytes) and, optionally, the status byte to page-1 memory (JSR, BRK, IRQ, NMI).
- Pull: reads the same bytes back in reverse order for RTS/RTI and presents them as registered bytes for the PC and P registers to load.
- Sits between the control unit, the PC/P registers and the memory bus.

Parameters:
STACK_PAGE, 8'h01, high address byte of every stack access
SP_RESET, 8'hFD, SP value after reset

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start_push  input  1  request a push sequence; sampled only in IDLE
start_pull  input  1  request a pull sequence; sampled only in IDLE
with_p  input  1  1: 3-byte sequence including P; 0: 2-byte PC-only sequence; sampled with start
pc_h_in  input  8  PC high byte to push; latched at accepted start_push
pc_l_in  input  8  PC low byte to push; latched at accepted start_push
p_in  input  8  status byte to push; latched at accepted start_push
sp_load  input  1  load SP from sp_in (TXS); honoured only in IDLE
sp_in  input  8  new SP value
mem_rdata  input  8  memory read data; valid in the cycle after mem_re
mem_addr  output  16  {STACK_PAGE, stack byte address}; 16'h0000 when not accessing
mem_wdata  output  8  write data; 8'h00 when mem_we low
mem_we  output  1  memory write strobe
mem_re  output  1  memory read strobe
sp_out  output  8  current SP
pc_h_out  output  8  pulled PC high byte (registered)
pc_l_out  output  8  pulled PC low byte (registered)
p_out  output  8  pulled status byte (registered)
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse, DONE state only

Behaviour:
- Reset values:
  - state IDLE; SP = SP_RESET.
  - mem_we, mem_re, done, busy = 0; mem_addr = 0; mem_wdata = 0.
  - pc_h_out, pc_l_out, p_out = 0.
- States: IDLE, PUSH, PULL, PULL_TAIL, DONE.
- N = 3 if with_p else 2. A byte counter (0..N-1) indexes the sequence.
- IDLE:
  - start_push (cycle T) latches operands, with_p and N, then goes to PUSH.
  - Otherwise start_pull latches with_p and N, then goes to PULL.
  - Both asserted: push wins; the pull is dropped, not queued.
  - sp_load with no start: SP <= sp_in. sp_load together with a start: start wins and sp_load is ignored.
- PUSH, cycles T+1..T+N:
  - mem_we = 1; mem_addr = {STACK_PAGE, SP}.
  - Byte order: PC_H, then PC_L, then P (when with_p).
  - SP <= SP-1 each cycle.
  - After byte N-1, go to DONE (done in cycle T+N+1).
- PULL, cycles T+1..T+N:
  - mem_re = 1; mem_addr = {STACK_PAGE, SP+1}; SP <= SP+1 each cycle.
  - Byte order: P (when with_p), then PC_L, then PC_H.
  - The data for the read issued in cycle k is captured into its destination register at the end of cycle k+1.
  - After byte N-1, go to PULL_TAIL at T+N+1: no strobe, final capture.
  - Then DONE (done in cycle T+N+2).
- DONE: done = 1, busy = 1, starts ignored; next cycle IDLE.
- Starts and sp_load in any non-IDLE state are ignored and not queued.
- SP arithmetic is 8-bit modulo:
  - Push from 8'h00 writes {STACK_PAGE,8'h00}, then SP = 8'hFF.
  - Pull from 8'hFF reads {STACK_PAGE,8'h00}.
  - Address never leaves the stack page.
- Pull output registers hold their value until the next pull overwrites them. A 2-byte pull leaves p_out unchanged.
- Reset asserted mid-sequence:
  - Next cycle: IDLE, reset values everywhere.
  - No further strobes and no done pulse.
  - Partially written memory is not restored.

Test Plan:
- Reset -> SP=FD, all strobes 0, busy=0. Then start_push with_p=1, pc=C0/12, p=24 -> writes 01FD=C0, 01FC=12, 01FB=24 on consecutive cycles; done at T+4; SP=FA.
- From SP=FA, start_pull with_p=1, memory model returns the bytes above -> reads 01FB, 01FC, 01FD; p_out=24, pc_l_out=12, pc_h_out=C0 valid at done (T+5); SP=FD.
- Wrap: sp_load sp_in=01, then push with_p=0, pc=AB/CD -> writes 0101=AB, 0100=CD; SP=FF. Pull with_p=0 -> reads 0100, 0101; pc_l=CD, pc_h=AB; SP=01; p_out unchanged.
- start_push and start_pull together in IDLE -> only a push occurs. A further start_pull plus sp_load during busy -> no effect, SP unchanged by sp_load.
- Reset asserted in the second PUSH cycle -> next cycle IDLE, SP=FD, mem_we=0, no done pulse.
- Back-to-back: start_pull asserted in the DONE cycle is ignored; reasserted in the following IDLE cycle it is accepted.
